// File: rtl/cw_bus_responder.sv
// cw_bus_responder: target-side endpoint of the 16-bit CW external bus.
// Serves reads and writes from a DEPTH x 16 register bank and answers with
// a one-cycle cw_ack (hit) or cw_err (miss) after WAIT_CYCLES wait states.
// Optional build macro CW_BUS_RESP_RAND_WAIT_EN adds 0..3 pseudo-random
// extra wait states per transaction from a 16-bit Galois LFSR.
module cw_bus_responder #(
    parameter int          DEPTH       = 16,
    parameter logic [15:0] ADDR_BASE   = 16'h0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        cw_rst,
    input  logic        cw_req,
    input  logic        cw_dir,
    input  logic [15:0] cw_io_i,
    output logic [15:0] cw_io_o,
    output logic        cw_io_oe,
    output logic        cw_ack,
    output logic        cw_err,
    output logic        o_busy
);

    localparam int          IDX_W   = $clog2(DEPTH);
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);
    localparam logic [4:0]  WAIT_LD = 5'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_WAIT,
        ST_RESP,
        ST_TURN
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        dir_q, dir_d;
    logic        hit_q, hit_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] mem_q [DEPTH];
    logic [15:0] mem_d [DEPTH];
    logic [15:0] io_o_q, io_o_d;
    logic        oe_q, oe_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;

    logic [15:0]      offset;
    logic [IDX_W-1:0] idx;
    logic             addr_hit;
    logic [4:0]       wait_total;

    // Offset into the bank; a wrap below ADDR_BASE produces a large offset and misses
    assign offset   = addr_q - ADDR_BASE;
    assign idx      = offset[IDX_W-1:0];
    assign addr_hit = ({1'b0, offset} < DEPTH_W);

`ifdef CW_BUS_RESP_RAND_WAIT_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Galois LFSR (taps 16,14,13,11) stepping once per transaction in DATA
    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == ST_DATA) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    // LFSR register, only the pad reset reseeds it so cw_rst keeps the sequence going
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign wait_total = WAIT_LD + {3'b000, lfsr_q[1:0]};
`else
    assign wait_total = WAIT_LD;
`endif

    // Transaction FSM next-state, field latching and write commit
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        dir_d   = dir_q;
        wdata_d = wdata_q;
        hit_d   = hit_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;

        case (state_q)
            ST_IDLE: begin
                if (cw_req) begin
                    addr_d  = cw_io_i;
                    dir_d   = cw_dir;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!cw_req) begin
                    state_d = ST_IDLE;
                end else begin
                    if (dir_q) begin
                        wdata_d = cw_io_i;
                    end
                    hit_d   = addr_hit;
                    cnt_d   = wait_total;
                    state_d = (wait_total != 5'd0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (!cw_req) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q <= 5'd1) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (hit_q && dir_q) begin
                    mem_d[idx] = wdata_q;
                end
                state_d = ST_TURN;
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bus reset wins over everything, including a write about to commit
        if (cw_rst) begin
            state_d = ST_IDLE;
            mem_d   = mem_q;
        end
    end

    // Registered response outputs, asserted only for the cycle spent in RESP
    always_comb begin
        ack_d  = 1'b0;
        err_d  = 1'b0;
        oe_d   = 1'b0;
        io_o_d = 16'h0000;
        if (state_d == ST_RESP) begin
            ack_d = hit_d;
            err_d = !hit_d;
            if (hit_d && !dir_q) begin
                oe_d   = 1'b1;
                io_o_d = mem_q[idx];
            end
        end
    end

    // State, field, storage and output registers; pad reset also clears storage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= 16'h0000;
            dir_q   <= 1'b0;
            wdata_q <= 16'h0000;
            hit_q   <= 1'b0;
            cnt_q   <= 5'd0;
            io_o_q  <= 16'h0000;
            oe_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 16'h0000;
            end
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dir_q   <= dir_d;
            wdata_q <= wdata_d;
            hit_q   <= hit_d;
            cnt_q   <= cnt_d;
            io_o_q  <= io_o_d;
            oe_q    <= oe_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            mem_q   <= mem_d;
        end
    end

    assign cw_io_o  = io_o_q;
    assign cw_io_oe = oe_q;
    assign cw_ack   = ack_q;
    assign cw_err   = err_q;
    assign o_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cw_bus_responder.sv
// Testbench for cw_bus_responder: scoreboard of expected responses pushed as
// each transaction is driven and popped by a monitor when cw_ack/cw_err fire.
// Define CW_BUS_RESP_RAND_WAIT_EN to exercise the random wait-state build.
module tb_cw_bus_responder;

    localparam int          DEPTH = 16;
    localparam logic [15:0] BASE  = 16'h0100;
    localparam int          WAITC = 1;
    localparam int          IDX_W = $clog2(DEPTH);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cw_rst = 1'b0;
    logic        cw_req = 1'b0;
    logic        cw_dir = 1'b0;
    logic [15:0] cw_io_i = 16'h0000;
    logic [15:0] cw_io_o;
    logic        cw_io_oe;
    logic        cw_ack;
    logic        cw_err;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        err;
        logic        rd;
        logic [15:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] model [DEPTH];
    int          lat_hist [4];

    cw_bus_responder #(
        .DEPTH       (DEPTH),
        .ADDR_BASE   (BASE),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .cw_rst   (cw_rst),
        .cw_req   (cw_req),
        .cw_dir   (cw_dir),
        .cw_io_i  (cw_io_i),
        .cw_io_o  (cw_io_o),
        .cw_io_oe (cw_io_oe),
        .cw_ack   (cw_ack),
        .cw_err   (cw_err),
        .o_busy   (o_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = 16'h0000;
        end
    endtask

    // Compute the expected response from the bench's own decode and storage model
    task automatic pushExpected(input logic dir, input logic [15:0] addr, input logic [15:0] wdata);
        logic [15:0]      off;
        logic             hit;
        logic [IDX_W-1:0] ix;
        exp_t             e;
        off     = addr - BASE;
        hit     = (off < 16'(DEPTH));
        ix      = off[IDX_W-1:0];
        e.err   = !hit;
        e.rd    = !dir;
        e.rdata = (hit && !dir) ? model[ix] : 16'h0000;
        exp_q.push_back(e);
        if (hit && dir) begin
            model[ix] = wdata;
        end
    endtask

    task automatic checkLatency(input string tag, input int lat, input int base_lat);
`ifdef CW_BUS_RESP_RAND_WAIT_EN
        checkOutput({tag, "_min"}, 32'(lat >= base_lat), 32'd1);
        checkOutput({tag, "_max"}, 32'(lat <= base_lat + 3), 32'd1);
        if (base_lat == 2 + WAITC && lat >= base_lat && lat <= base_lat + 3) begin
            lat_hist[lat - base_lat]++;
        end
`else
        checkOutput(tag, 32'(lat), 32'(base_lat));
`endif
    endtask

    // Monitor: every response is matched against the oldest expected entry
    always @(negedge clk) begin
        if (rst_n && (cw_ack || cw_err)) begin
            checkOutput("ack_err_excl", 32'(cw_ack & cw_err), 32'd0);
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_resp", {30'd0, cw_ack, cw_err}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("resp_err", 32'(cw_err), 32'(mon_e.err));
                checkOutput("resp_ack", 32'(cw_ack), 32'(!mon_e.err));
                checkOutput("resp_oe", 32'(cw_io_oe), 32'(mon_e.rd && !mon_e.err));
                checkOutput("resp_data", 32'(cw_io_o), 32'(mon_e.rdata));
            end
        end
        if (rst_n && cw_io_oe && !cw_ack) begin
            checkOutput("oe_without_ack", 32'(cw_io_oe), 32'd0);
        end
    end

    // One full transaction; optionally pulses the pad reset in the middle of RESP
    task automatic applyStimulus(input logic dir, input logic [15:0] addr, input logic [15:0] wdata,
                                 input logic rst_in_resp);
        int   lat;
        logic seen;
        pushExpected(dir, addr, wdata);
        @(negedge clk);
        cw_req  = 1'b1;
        cw_dir  = dir;
        cw_io_i = addr;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        cw_io_i = wdata;
        cw_dir  = ~dir;
        seen    = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (cw_ack || cw_err) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checkOutput("resp_seen", 32'(seen), 32'd1);
        if (!seen) begin
            if (exp_q.size() > 0) begin
                void'(exp_q.pop_back());
            end
            cw_req = 1'b0;
            return;
        end
        checkLatency("latency", lat, 2 + WAITC);
        if (rst_in_resp) begin
            #1 rst_n = 1'b0;
            #1;
            checkOutput("arst_ack", 32'(cw_ack), 32'd0);
            checkOutput("arst_oe", 32'(cw_io_oe), 32'd0);
            checkOutput("arst_data", 32'(cw_io_o), 32'd0);
            checkOutput("arst_busy", 32'(o_busy), 32'd0);
            #1 rst_n = 1'b1;
            cw_req = 1'b0;
            cw_dir = 1'b0;
            clearModel();
            @(posedge clk);
            return;
        end
        cw_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("turn_oe", 32'(cw_io_oe), 32'd0);
        checkOutput("turn_resp", 32'(cw_ack | cw_err), 32'd0);
        @(posedge clk);
    endtask

    // Starts a write and interrupts it in WAIT, either by dropping req or by cw_rst
    task automatic interruptInWait(input logic [15:0] addr, input logic [15:0] wdata, input logic use_bus_rst);
        @(negedge clk);
        cw_req  = 1'b1;
        cw_dir  = 1'b1;
        cw_io_i = addr;
        @(posedge clk);
        @(negedge clk);
        cw_io_i = wdata;
        @(posedge clk);
        @(negedge clk);
        checkOutput("wait_busy", 32'(o_busy), 32'd1);
        if (use_bus_rst) begin
            cw_rst = 1'b1;
        end else begin
            cw_req = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        cw_rst = 1'b0;
        cw_req = 1'b0;
        checkOutput("intr_busy", 32'(o_busy), 32'd0);
        checkOutput("intr_resp", 32'(cw_ack | cw_err), 32'd0);
        checkOutput("intr_oe", 32'(cw_io_oe), 32'd0);
        checkOutput("intr_data", 32'(cw_io_o), 32'd0);
        repeat (8) @(posedge clk);
    endtask

    // Two writes with req held high throughout; measures the re-sample period
    task automatic backToBack();
        int   k;
        logic prev_busy;
        logic found;
        logic seen;
        pushExpected(1'b1, 16'h0107, 16'hA1A1);
        pushExpected(1'b1, 16'h0108, 16'hB2B2);
        @(negedge clk);
        cw_req  = 1'b1;
        cw_dir  = 1'b1;
        cw_io_i = 16'h0107;
        @(posedge clk);
        @(negedge clk);
        cw_io_i   = 16'hA1A1;
        k         = 0;
        prev_busy = 1'b1;
        found     = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (k == 1) begin
                cw_io_i = 16'h0108;
            end
            if (!prev_busy && o_busy) begin
                found = 1'b1;
                break;
            end
            prev_busy = o_busy;
        end
        checkOutput("b2b_resample", 32'(found), 32'd1);
        checkLatency("b2b_period", k, 4 + WAITC);
        cw_io_i = 16'hB2B2;
        seen    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (cw_ack || cw_err) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("b2b_second_resp", 32'(seen), 32'd1);
        cw_req = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        clearModel();
        for (int i = 0; i < 4; i++) begin
            lat_hist[i] = 0;
        end
        $display("[TB] start");

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ack", 32'(cw_ack), 32'd0);
        checkOutput("rst_err", 32'(cw_err), 32'd0);
        checkOutput("rst_oe", 32'(cw_io_oe), 32'd0);
        checkOutput("rst_data", 32'(cw_io_o), 32'd0);
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] write/read hit");
        applyStimulus(1'b1, 16'h0103, 16'hBEEF, 1'b0);
        applyStimulus(1'b0, 16'h0103, 16'h0000, 1'b0);
        applyStimulus(1'b1, 16'h0100, 16'h5A5A, 1'b0);
        applyStimulus(1'b1, 16'h010F, 16'h1111, 1'b0);

        $display("[TB] address misses");
        applyStimulus(1'b0, 16'h0110, 16'h0000, 1'b0);
        applyStimulus(1'b1, 16'h00FF, 16'hDEAD, 1'b0);
        applyStimulus(1'b0, 16'h0100, 16'h0000, 1'b0);
        applyStimulus(1'b0, 16'h010F, 16'h0000, 1'b0);

        $display("[TB] abort in WAIT");
        interruptInWait(16'h0105, 16'h1234, 1'b0);
        applyStimulus(1'b0, 16'h0105, 16'h0000, 1'b0);

        $display("[TB] back-to-back writes");
        backToBack();
        applyStimulus(1'b0, 16'h0107, 16'h0000, 1'b0);
        applyStimulus(1'b0, 16'h0108, 16'h0000, 1'b0);

        $display("[TB] bus reset in WAIT");
        interruptInWait(16'h0106, 16'h7777, 1'b1);
        applyStimulus(1'b0, 16'h0106, 16'h0000, 1'b0);
        applyStimulus(1'b0, 16'h0103, 16'h0000, 1'b0);

        $display("[TB] async reset in RESP");
        applyStimulus(1'b0, 16'h0103, 16'h0000, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, BASE + 16'(i), 16'h0000, 1'b0);
        end

`ifdef CW_BUS_RESP_RAND_WAIT_EN
        $display("[TB] random wait states");
        for (int i = 0; i < 4; i++) begin
            lat_hist[i] = 0;
        end
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b0, BASE + 16'(i % DEPTH), 16'h0000, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            checkOutput("rand_lat_seen", 32'(lat_hist[i] > 0), 32'd1);
        end
`endif

        repeat (4) @(posedge clk);
        checkOutput("pending_resp", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cw_bus_responder.md
Name: cw_bus_responder

Overview:
- Target-side endpoint of the 16-bit CW external bus; the responder counterpart to the CW bus initiator in top_cw.
- Decodes address/data words from the initiator, serves reads and writes from an internal DEPTH x 16 register bank, and returns cw_ack or cw_err after configurable wait states.
- Used as the bus-functional peripheral model in system benches and as the synthesizable on-chip loopback target behind the CW pads.

Parameters:
- DEPTH, 16, number of 16-bit storage words (power of 2, 2..256)
- ADDR_BASE, 16'h0000, first decoded bus address; hit range is ADDR_BASE .. ADDR_BASE+DEPTH-1
- WAIT_CYCLES, 1, wait states between the data phase and the response phase (0..15)

Ports:
- i_clk  in  1  CW bus clock (cw_clk from the initiator); all logic on the rising edge
- i_rst_n  in  1  asynchronous active-low reset
- cw_rst  in  1  synchronous bus reset from the initiator, active-high
- cw_req  in  1  transaction request, held by the initiator until the response is sampled
- cw_dir  in  1  1 = write, 0 = read; sampled with the address
- cw_io_i  in  16  bus word from the initiator (address, then write data)
- cw_io_o  out  16  read data driven to the initiator
- cw_io_oe  out  1  1 = responder drives cw_io_o (pad oeb = ~cw_io_oe)
- cw_ack  out  1  one-cycle successful completion
- cw_err  out  1  one-cycle error completion (address miss)
- o_busy  out  1  FSM not in IDLE

Behaviour:
- Reset (i_rst_n low, async):
  - FSM to IDLE.
  - cw_io_o=0, cw_io_oe=0, cw_ack=0, cw_err=0, o_busy=0.
  - Storage cleared to 0.
- cw_rst high: at the clock edge, FSM to IDLE and all outputs to 0; storage is kept. cw_rst has priority over every FSM transition.
- IDLE:
  - If cw_req=1, latch addr=cw_io_i and dir=cw_dir, then go to DATA.
  - If cw_req=0, stay in IDLE.
- DATA (1 cycle):
  - If dir=1, latch wdata=cw_io_i.
  - Evaluate hit = (addr - ADDR_BASE) < DEPTH, using 16-bit unsigned subtraction; wrap below ADDR_BASE counts as a miss.
  - Load wait counter with WAIT_CYCLES. Go to WAIT if the count is nonzero, else go to RESP.
- WAIT: decrement each cycle; go to RESP on the cycle the counter reaches 0.
- RESP (1 cycle):
  - Hit: cw_ack=1.
    - Read: cw_io_oe=1 and cw_io_o=mem[addr-ADDR_BASE].
    - Write: commit mem[addr-ADDR_BASE]=wdata at the end of this cycle.
  - Miss: cw_err=1, no write, cw_io_oe=0, cw_io_o=0.
  - Next state is TURN.
- TURN (1 cycle):
  - Bus turnaround. cw_io_oe=0. cw_req is ignored so the initiator can release it.
  - Next state is IDLE.
- Outputs are registered. cw_ack, cw_err and cw_io_oe are high only in RESP, and cw_ack and cw_err are never high together.
- Latency: req sampled at edge N, response visible in cycle N+2+WAIT_CYCLES. Minimum back-to-back period is 4+WAIT_CYCLES cycles.
- Abort: cw_req=0 in DATA or WAIT returns the FSM to IDLE with no response and no write.
- cw_req low during RESP is legal; the response is still issued.
- cw_dir and cw_io_i changes after their sample cycle are ignored.
- Async reset mid-transaction: no write occurs, and a pending ack/err is dropped immediately.
- Only the low log2(DEPTH) bits of the offset index storage.

Optional Feature:
- Macro: CW_BUS_RESP_RAND_WAIT_EN.
- Defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11, seed 16'hACE1, reset by i_rst_n only) advances once per transaction, in the DATA cycle.
  - Its 2 LSBs are added to WAIT_CYCLES, giving WAIT_CYCLES..WAIT_CYCLES+3 wait states. This stresses initiator timeout and wait handling.
- Undefined: no LFSR logic is built and the wait is exactly WAIT_CYCLES.

Test Plan:
- WAIT_CYCLES=1: write addr 16'h0003, data 16'hBEEF, req at edge 0.
  - Required: cw_ack=1 in cycle 3 only, cw_err=0.
  - Then read 16'h0003: cw_io_oe=1 and cw_io_o=16'hBEEF in the ack cycle, cw_io_oe=0 in the following cycle.
- DEPTH=16, ADDR_BASE=16'h0100: read 16'h0110 and write 16'h00FF.
  - Required: cw_err=1 for one cycle each, cw_ack=0, storage unchanged.
  - A readback of 16'h0100 returns its old value.
- Write 16'h1234 to addr 5, dropping cw_req in the WAIT cycle.
  - Required: no ack and no err, FSM in IDLE within 1 cycle, mem[5] still 0.
- Two back-to-back writes, with req held high through TURN.
  - Required: the second address is sampled exactly 4+WAIT_CYCLES cycles after the first; both words are stored.
- Assert cw_rst during WAIT of a write.
  - Required: outputs 0 next cycle, o_busy=0, no write; earlier stored data is preserved.
- Pulse i_rst_n low asynchronously between edges during RESP.
  - Required: cw_ack/cw_io_oe drop immediately; all words read back 0.
- With CW_BUS_RESP_RAND_WAIT_EN defined: 64 reads.
  - Required: every response latency lies in 2+WAIT_CYCLES..5+WAIT_CYCLES, and all four values occur.
